// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the AES round sequencer and the byte-serial datapath.
// master = sequencer side, slave = datapath/top side.
interface aes_round_ctrl_if #(
   parameter int unsigned IDX_W = 4
) ();
   logic             start_system;
   logic             abort;
   logic             load_en;
   logic             ark0_en;
   logic             key_en;
   logic             sub_en;
   logic             shift_en;
   logic             mix_en;
   logic             ark_en;
   logic             out_en;
   logic [IDX_W-1:0] byte_idx;
   logic [3:0]       round;
   logic [7:0]       rcon;
   logic             busy;
   logic             DONE;

   modport master (
      input  start_system, abort,
      output load_en, ark0_en, key_en, sub_en, shift_en, mix_en, ark_en, out_en,
      output byte_idx, round, rcon, busy, DONE
   );

   modport slave (
      output start_system, abort,
      input  load_en, ark0_en, key_en, sub_en, shift_en, mix_en, ark_en, out_en,
      input  byte_idx, round, rcon, busy, DONE
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Phase sequencer for the byte-serial AES-128 encryption datapath: load, ARK0,
// NR rounds (KEY/SUB/SHIFT/MIX/ARK), readout, then a one-cycle DONE pulse.
module aes_round_ctrl #(
   parameter int unsigned NB         = 16,
   parameter int unsigned NR         = 10,
   parameter int unsigned KEY_CYCLES = 4,
   parameter int unsigned MIX_CYCLES = 4
) (
   input logic              clk,
   input logic              rst,
   aes_round_ctrl_if.master ctrl
);
   localparam int unsigned IDX_W = $clog2(NB);

   localparam logic [3:0] StIdle  = 4'd0;
   localparam logic [3:0] StLoad  = 4'd1;
   localparam logic [3:0] StArk0  = 4'd2;
   localparam logic [3:0] StKey   = 4'd3;
   localparam logic [3:0] StSub   = 4'd4;
   localparam logic [3:0] StShift = 4'd5;
   localparam logic [3:0] StMix   = 4'd6;
   localparam logic [3:0] StArk   = 4'd7;
   localparam logic [3:0] StOut   = 4'd8;
   localparam logic [3:0] StDone  = 4'd9;

   logic [3:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       round_q, round_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [IDX_W-1:0] last_idx;
   logic             last_round;
   logic [7:0]       rcon_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         round_q <= '0;
         rcon_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
      end
   end

   // Terminal index of the current phase; single-cycle phases end at 0.
   always_comb begin
      last_idx = '0;
      unique case (state_q)
         StLoad, StArk0, StSub, StArk, StOut: last_idx = IDX_W'(NB - 1);
         StKey:                               last_idx = IDX_W'(KEY_CYCLES - 1);
         StMix:                               last_idx = IDX_W'(MIX_CYCLES - 1);
         default:                             last_idx = '0;
      endcase
   end

   assign last_round = (round_q == 4'(NR));
   // xtime in GF(2^8): shift left, reduce by 0x1B on carry-out.
   assign rcon_next  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      if (state_q == StIdle) begin
         if (ctrl.start_system && !ctrl.abort) begin
            state_d = StLoad;
         end
      end else if (ctrl.abort || state_q == StDone) begin
         state_d = StIdle;
         idx_d   = '0;
         round_d = '0;
         rcon_d  = '0;
      end else if (idx_q != last_idx) begin
         idx_d = idx_q + IDX_W'(1);
      end else begin
         idx_d = '0;
         unique case (state_q)
            StLoad: state_d = StArk0;
            StArk0: begin
               state_d = StKey;
               round_d = 4'd1;
               rcon_d  = 8'h01;
            end
            StKey:   state_d = StSub;
            StSub:   state_d = StShift;
            StShift: state_d = last_round ? StArk : StMix;
            StMix:   state_d = StArk;
            StArk: begin
               if (last_round) begin
                  state_d = StOut;
               end else begin
                  state_d = StKey;
                  round_d = round_q + 4'd1;
                  rcon_d  = rcon_next;
               end
            end
            StOut:   state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      ctrl.load_en  = (state_q == StLoad);
      ctrl.ark0_en  = (state_q == StArk0);
      ctrl.key_en   = (state_q == StKey);
      ctrl.sub_en   = (state_q == StSub);
      ctrl.shift_en = (state_q == StShift);
      ctrl.mix_en   = (state_q == StMix);
      ctrl.ark_en   = (state_q == StArk);
      ctrl.out_en   = (state_q == StOut);
      ctrl.byte_idx = idx_q;
      ctrl.round    = round_q;
      // rcon_q is kept for the whole round but only exposed while KEY runs.
      ctrl.rcon     = (state_q == StKey) ? rcon_q : 8'h00;
      ctrl.busy     = (state_q != StIdle);
      ctrl.DONE     = (state_q == StDone);
   end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: checkpoint table over one full block plus
// abort, async reset and back-to-back start sequences.
module tb_aes_round_ctrl;
   typedef struct {
      int          cyc;
      logic [25:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_round_ctrl_if #(.IDX_W(4)) bus ();

   aes_round_ctrl dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus.master)
   );

   int checks = 0;
   int errors = 0;

   // Scoreboard counters, sampled on the falling edge.
   int sub_cnt, key_cnt, out_cnt, mix_phases, done_cnt, onehot_bad, rcon_bad;
   logic prev_mix;
   logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] ens();
      return {bus.load_en, bus.ark0_en, bus.key_en, bus.sub_en,
              bus.shift_en, bus.mix_en, bus.ark_en, bus.out_en};
   endfunction

   function automatic logic [25:0] obs();
      return {ens(), bus.byte_idx, bus.round, bus.rcon, bus.busy, bus.DONE};
   endfunction

   function automatic logic [25:0] mk(input logic [7:0] en, input int idx, input int rnd,
                                      input logic [7:0] rc, input logic bsy, input logic dn);
      return {en, 4'(idx), 4'(rnd), rc, bsy, dn};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      sub_cnt = 0; key_cnt = 0; out_cnt = 0; mix_phases = 0;
      done_cnt = 0; onehot_bad = 0; rcon_bad = 0; prev_mix = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         int r;
         r = int'(bus.round);
         if ($countones(ens()) > 1) onehot_bad++;
         if (bus.sub_en) sub_cnt++;
         if (bus.out_en) out_cnt++;
         if (bus.DONE) done_cnt++;
         if (bus.mix_en && !prev_mix) mix_phases++;
         prev_mix = bus.mix_en;
         if (bus.key_en) begin
            key_cnt++;
            if (r < 1 || r > 10) rcon_bad++;
            else if (bus.rcon !== rcon_tab[r-1]) rcon_bad++;
         end else if (bus.rcon !== 8'h00) begin
            rcon_bad++;
         end
      end
   end

   localparam logic [7:0] E_LOAD = 8'h80, E_ARK0 = 8'h40, E_KEY = 8'h20, E_SUB = 8'h10;
   localparam logic [7:0] E_SHIFT = 8'h08, E_MIX = 8'h04, E_ARK = 8'h02, E_OUT = 8'h01;

   vec_t vec [28];

   initial begin
      int cyc, ptr, n, idle_cnt;

      vec[0]  = '{1,   mk(E_LOAD,  0,  0, 8'h00, 1, 0)};
      vec[1]  = '{16,  mk(E_LOAD,  15, 0, 8'h00, 1, 0)};
      vec[2]  = '{17,  mk(E_ARK0,  0,  0, 8'h00, 1, 0)};
      vec[3]  = '{32,  mk(E_ARK0,  15, 0, 8'h00, 1, 0)};
      vec[4]  = '{33,  mk(E_KEY,   0,  1, 8'h01, 1, 0)};
      vec[5]  = '{36,  mk(E_KEY,   3,  1, 8'h01, 1, 0)};
      vec[6]  = '{37,  mk(E_SUB,   0,  1, 8'h00, 1, 0)};
      vec[7]  = '{52,  mk(E_SUB,   15, 1, 8'h00, 1, 0)};
      vec[8]  = '{53,  mk(E_SHIFT, 0,  1, 8'h00, 1, 0)};
      vec[9]  = '{54,  mk(E_MIX,   0,  1, 8'h00, 1, 0)};
      vec[10] = '{57,  mk(E_MIX,   3,  1, 8'h00, 1, 0)};
      vec[11] = '{58,  mk(E_ARK,   0,  1, 8'h00, 1, 0)};
      vec[12] = '{73,  mk(E_ARK,   15, 1, 8'h00, 1, 0)};
      vec[13] = '{74,  mk(E_KEY,   0,  2, 8'h02, 1, 0)};
      vec[14] = '{361, mk(E_KEY,   0,  9, 8'h1b, 1, 0)};
      vec[15] = '{401, mk(E_ARK,   15, 9, 8'h00, 1, 0)};
      vec[16] = '{402, mk(E_KEY,   0, 10, 8'h36, 1, 0)};
      vec[17] = '{405, mk(E_KEY,   3, 10, 8'h36, 1, 0)};
      vec[18] = '{406, mk(E_SUB,   0, 10, 8'h00, 1, 0)};
      vec[19] = '{421, mk(E_SUB,   15, 10, 8'h00, 1, 0)};
      vec[20] = '{422, mk(E_SHIFT, 0, 10, 8'h00, 1, 0)};
      vec[21] = '{423, mk(E_ARK,   0, 10, 8'h00, 1, 0)};
      vec[22] = '{438, mk(E_ARK,   15, 10, 8'h00, 1, 0)};
      vec[23] = '{439, mk(E_OUT,   0, 10, 8'h00, 1, 0)};
      vec[24] = '{454, mk(E_OUT,   15, 10, 8'h00, 1, 0)};
      vec[25] = '{455, mk(8'h00,   0, 10, 8'h00, 1, 1)};
      vec[26] = '{456, mk(8'h00,   0,  0, 8'h00, 0, 0)};
      vec[27] = '{457, mk(8'h00,   0,  0, 8'h00, 0, 0)};

      rst = 1'b1;
      bus.start_system = 1'b0;
      bus.abort = 1'b0;
      clear_mon();
      repeat (3) step();
      chk("reset_outputs", 32'(obs()), 32'h0);
      rst = 1'b0;
      step();
      step();
      chk("idle_after_reset", 32'(obs()), 32'h0);

      // abort beats start in IDLE
      bus.start_system = 1'b1;
      bus.abort = 1'b1;
      step();
      chk("abort_start_idle", 32'(obs()), 32'h0);
      bus.start_system = 1'b0;
      bus.abort = 1'b0;
      step();

      // Full block against the checkpoint table; stray starts at 50 and 455.
      clear_mon();
      bus.start_system = 1'b1;
      step();
      cyc = 1;
      ptr = 0;
      while (cyc <= 457) begin
         bus.start_system = (cyc == 50 || cyc == 455);
         @(negedge clk);
         if (ptr < 28 && vec[ptr].cyc == cyc) begin
            chk($sformatf("vec_cyc%0d", cyc), 32'(obs()), 32'(vec[ptr].exp));
            ptr++;
         end
         step();
         cyc++;
      end
      bus.start_system = 1'b0;
      chk("vec_all_hit", 32'(ptr), 32'd28);
      chk("sub_cycles", 32'(sub_cnt), 32'd160);
      chk("mix_phases", 32'(mix_phases), 32'd9);
      chk("key_cycles", 32'(key_cnt), 32'd40);
      chk("out_cycles", 32'(out_cnt), 32'd16);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("onehot_violations", 32'(onehot_bad), 32'd0);
      chk("rcon_errors", 32'(rcon_bad), 32'd0);

      // Abort at cycle 200, restart at 210.
      clear_mon();
      bus.start_system = 1'b1;
      step();
      bus.start_system = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         step();
         cyc++;
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      cyc = 201;
      chk("abort_outputs", 32'(obs()), 32'h0);
      while (cyc < 210) begin
         step();
         cyc++;
      end
      chk("abort_stays_idle", 32'(obs()), 32'h0);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      bus.start_system = 1'b1;
      step();
      bus.start_system = 1'b0;
      n = 1;
      while (!bus.DONE && n < 600) begin
         step();
         n++;
      end
      chk("restart_done_cycle", 32'(210 + n), 32'd665);
      step();

      // Abort on the last LOAD cycle wins over the LOAD->ARK0 transition.
      bus.start_system = 1'b1;
      step();
      bus.start_system = 1'b0;
      repeat (15) step();
      chk("at_load_last", 32'(obs()), 32'(mk(E_LOAD, 15, 0, 8'h00, 1, 0)));
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_on_transition", 32'(obs()), 32'h0);

      // Asynchronous reset mid-SUB.
      clear_mon();
      bus.start_system = 1'b1;
      step();
      bus.start_system = 1'b0;
      repeat (39) step();
      chk("mid_sub_state", 32'(obs()), 32'(mk(E_SUB, 3, 1, 8'h00, 1, 0)));
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", 32'(obs()), 32'h0);
      #3;
      rst = 1'b0;
      repeat (20) step();
      chk("post_reset_idle", 32'(obs()), 32'h0);
      chk("post_reset_no_done", 32'(done_cnt), 32'd0);

      // start_system held high: blocks run back to back, one IDLE cycle apart.
      bus.start_system = 1'b1;
      step();
      n = 1;
      while (!bus.DONE && n < 600) begin
         step();
         n++;
      end
      chk("held_first_done", 32'(n), 32'd455);
      n = 0;
      idle_cnt = 0;
      do begin
         step();
         n++;
         if (!bus.busy) idle_cnt++;
      end while (!bus.DONE && n < 1000);
      chk("held_done_gap", 32'(n), 32'd456);
      chk("held_idle_gap", 32'(idle_cnt), 32'd1);
      bus.start_system = 1'b0;
      step();
      chk("held_release_idle", 32'(obs()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
